// File: rtl/instr_mem_responder_pkg.sv
// Shared fetch-response types for the instruction memory responder.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } fetch_rsp_t;

endpackage

// File: rtl/instr_mem_responder_fifo.sv
// Response buffer for the instruction memory responder: a small synchronous
// FIFO with push/pop/flush that accepts a push into a full FIFO when a pop happens in the same cycle.
module sync_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T              store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = store[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + ($clog2(DEPTH) + 1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH) + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage holds no control state; pointers and count decide what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !(rst_i || flush)) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch responder: word-addressed instruction memory, LATENCY-stage response
// pipeline and response FIFO. Define MISALIGN_TRAP_EN to flag misaligned fetches.
module instr_mem_responder
  import fetch_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        flush_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_addr_o,
  output logic [31:0] rsp_instr_o,
  output logic        rsp_err_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [IW-1:0]      rd_idx;
  logic [IW-1:0]      ld_idx;
  fetch_rsp_t         rd_entry;
  logic [LATENCY-1:0] stg_valid;
  fetch_rsp_t         stg_data [LATENCY];
  logic [CW-1:0]      outstanding;
  logic               flush_any;
  logic               accept;
  logic               pop_ok;
  fetch_rsp_t         fifo_out;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CW-1:0]      fifo_count;
  logic               unused;

  assign rd_idx    = req_addr_i[IW+1:2];
  assign ld_idx    = ld_addr_i[IW+1:2];
  assign flush_any = rst_i || flush_i;

  // outstanding already counts FIFO entries, so this bound keeps the FIFO from overflowing.
  assign req_ready_o = !flush_any && (outstanding < CW'(FIFO_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign pop_ok      = !fifo_empty && rsp_ready_i && !flush_any;

  // NOTE: the memory array is never reset; only control state is.
  always_ff @(posedge clk_i) begin
    if (ld_we_i) mem[ld_idx] <= ld_data_i;
  end

  // NOTE: every field gets a default before any condition, so no latch is inferred.
  always_comb begin
    rd_entry.addr  = req_addr_i;
    rd_entry.instr = mem[rd_idx];
    rd_entry.err   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (req_addr_i[1:0] != 2'b00) begin
      rd_entry.err   = 1'b1;
      rd_entry.instr = NOP_INSTR;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (flush_any) begin
      stg_valid <= '0;
    end else begin
      stg_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) stg_valid[i] <= stg_valid[i-1];
    end
  end

  // Payload moves alongside the valids; a stale payload is harmless once its valid is clear.
  always_ff @(posedge clk_i) begin
    stg_data[0] <= rd_entry;
    for (int i = 1; i < LATENCY; i++) stg_data[i] <= stg_data[i-1];
  end

  always_ff @(posedge clk_i) begin
    if (flush_any) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  sync_fifo #(
    .T     (fetch_rsp_t),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (flush_i),
    .push  (stg_valid[LATENCY-1]),
    .wdata (stg_data[LATENCY-1]),
    .pop   (pop_ok),
    .rdata (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read zero whenever no response is available.
  assign rsp_valid_o = !fifo_empty;
  assign rsp_addr_o  = fifo_empty ? '0 : fifo_out.addr;
  assign rsp_instr_o = fifo_empty ? '0 : fifo_out.instr;
`ifdef MISALIGN_TRAP_EN
  assign rsp_err_o   = !fifo_empty && fifo_out.err;
`else
  assign rsp_err_o   = 1'b0;
`endif

  assign unused = ^{ld_addr_i, fifo_full, fifo_count, fifo_out.err};

endmodule
